// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: id_ctrl bit layout, register
// address width, bubble encoding and hazard FSM states.
package mips_pkg;

    localparam int unsigned CTRL_W      = 8;
    localparam int unsigned REG_ADDR_W  = 5;
    localparam int unsigned STALL_CNT_W = 2;

    // id_ctrl = {reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, alu_op[1:0]}
    localparam int unsigned CTRL_REG_WRITE  = 7;
    localparam int unsigned CTRL_MEM_READ   = 6;
    localparam int unsigned CTRL_MEM_WRITE  = 5;
    localparam int unsigned CTRL_MEM_TO_REG = 4;
    localparam int unsigned CTRL_ALU_SRC    = 3;
    localparam int unsigned CTRL_REG_DST    = 2;
    localparam int unsigned CTRL_ALU_OP     = 0;
    localparam int unsigned CTRL_ALU_OP_W   = 2;

    localparam logic [CTRL_W-1:0] BUBBLE_CTRL = 8'h00;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } hz_state_t;

    typedef struct packed {
        logic                     reg_write;
        logic                     mem_read;
        logic                     mem_write;
        logic                     mem_to_reg;
        logic                     alu_src;
        logic                     reg_dst;
        logic [CTRL_ALU_OP_W-1:0] alu_op;
    } id_ctrl_t;

    // Unpack a raw control byte into named fields.
    function automatic id_ctrl_t ctrl_fields(input logic [CTRL_W-1:0] c);
        id_ctrl_t f;
        f.reg_write  = c[CTRL_REG_WRITE];
        f.mem_read   = c[CTRL_MEM_READ];
        f.mem_write  = c[CTRL_MEM_WRITE];
        f.mem_to_reg = c[CTRL_MEM_TO_REG];
        f.alu_src    = c[CTRL_ALU_SRC];
        f.reg_dst    = c[CTRL_REG_DST];
        f.alu_op     = c[CTRL_ALU_OP +: CTRL_ALU_OP_W];
        return f;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: a load in EX whose destination
// is a source of the valid instruction in ID.
module load_use_detect
    import mips_pkg::*;
(
    input  logic                  ex_valid,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_reg_dest,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_reg_rs,
    input  logic [REG_ADDR_W-1:0] id_reg_rt,
    input  logic                  id_uses_rt,
    output logic                  haz_c
);

    logic dest_nonzero;
    logic rs_match;
    logic rt_match;

    assign dest_nonzero = (ex_reg_dest != REG_ADDR_W'(0));
    assign rs_match     = (ex_reg_dest == id_reg_rs);
    assign rt_match     = id_uses_rt && (ex_reg_dest == id_reg_rt);

    assign haz_c = ex_valid && ex_mem_read && dest_nonzero && id_valid
                   && (rs_match || rt_match);

endmodule

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use stall and branch flush.
// Optional macro STALL_COUNTER_EN adds a saturating stall_count output.
module id_ex_hazard_reg
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STALL_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_reg_rs,
    input  logic [REG_ADDR_W-1:0] id_reg_rt,
    input  logic [REG_ADDR_W-1:0] id_reg_rd,
    input  logic                  id_uses_rt,
    input  logic [DATA_W-1:0]     id_read_data_1,
    input  logic [DATA_W-1:0]     id_read_data_2,
    input  logic [DATA_W-1:0]     id_imm,
    input  logic [CTRL_W-1:0]     id_ctrl,
    output logic [REG_ADDR_W-1:0] EX_reg_rs,
    output logic [REG_ADDR_W-1:0] EX_reg_rt,
    output logic [REG_ADDR_W-1:0] EX_reg_dest,
    output logic [DATA_W-1:0]     EX_read_data_1,
    output logic [DATA_W-1:0]     EX_read_data_2,
    output logic [DATA_W-1:0]     EX_imm,
    output logic [CTRL_W-1:0]     EX_ctrl,
    output logic                  EX_valid,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  stall
`ifdef STALL_COUNTER_EN
    ,
    output logic [31:0]           stall_count
`endif
);

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic [REG_ADDR_W-1:0] dest;
        logic [DATA_W-1:0]     rd1;
        logic [DATA_W-1:0]     rd2;
        logic [DATA_W-1:0]     imm;
        logic [CTRL_W-1:0]     ctrl;
    } ex_reg_t;

    hz_state_t              state_q;
    hz_state_t              state_d;
    logic [STALL_CNT_W-1:0] cnt_q;
    logic [STALL_CNT_W-1:0] cnt_d;
    logic                   haz;
    logic                   load_bubble;
    ex_reg_t                ex_q;
    ex_reg_t                ex_d;

    load_use_detect u_load_use_detect (
        .ex_valid    (ex_q.valid),
        .ex_mem_read (ex_q.ctrl[CTRL_MEM_READ]),
        .ex_reg_dest (ex_q.dest),
        .id_valid    (id_valid),
        .id_reg_rs   (id_reg_rs),
        .id_reg_rt   (id_reg_rt),
        .id_uses_rt  (id_uses_rt),
        .haz_c       (haz)
    );

    // Hazard FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, bubble request and stall; flush overrides everything.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        load_bubble = 1'b0;
        stall       = 1'b0;
        if (flush) begin
            state_d     = ST_IDLE;
            cnt_d       = '0;
            load_bubble = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (haz) begin
                        stall       = 1'b1;
                        load_bubble = 1'b1;
                        if (STALL_CYCLES > 1) begin
                            state_d = ST_STALL;
                            cnt_d   = STALL_CNT_W'(STALL_CYCLES - 1);
                        end
                    end
                end
                ST_STALL: begin
                    stall       = 1'b1;
                    load_bubble = 1'b1;
                    cnt_d       = cnt_q - STALL_CNT_W'(1);
                    if (cnt_q <= STALL_CNT_W'(1)) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign pc_write    = ~stall;
    assign if_id_write = ~stall;

    // Next EX contents: all-zero bubble or the decoded ID instruction.
    always_comb begin
        ex_d      = '0;
        ex_d.ctrl = BUBBLE_CTRL;
        if (!load_bubble && id_valid) begin
            ex_d.valid = 1'b1;
            ex_d.rs    = id_reg_rs;
            ex_d.rt    = id_reg_rt;
            ex_d.dest  = id_ctrl[CTRL_REG_DST] ? id_reg_rd : id_reg_rt;
            ex_d.rd1   = id_read_data_1;
            ex_d.rd2   = id_read_data_2;
            ex_d.imm   = id_imm;
            ex_d.ctrl  = id_ctrl;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign EX_valid       = ex_q.valid;
    assign EX_reg_rs      = ex_q.rs;
    assign EX_reg_rt      = ex_q.rt;
    assign EX_reg_dest    = ex_q.dest;
    assign EX_read_data_1 = ex_q.rd1;
    assign EX_read_data_2 = ex_q.rd2;
    assign EX_imm         = ex_q.imm;
    assign EX_ctrl        = ex_q.ctrl;

`ifdef STALL_COUNTER_EN
    // Saturating count of stalled clock edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count <= '0;
        end else if (stall && !flush && (stall_count != 32'hFFFF_FFFF)) begin
            stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: doc/id_ex_hazard_reg.md
Name: id_ex_hazard_reg

Overview:
- ID/EX pipeline register for the 5-stage MIPS pipeline, with integrated load-use hazard detection and bubble insertion.
- Captures decoded ID fields each cycle and drives the EX-stage register numbers, operands and controls consumed by the forwarding unit and the ALU.
- Stalls PC and IF/ID when a load in EX feeds the instruction in ID; flushes on a taken branch.

Parameters:
- DATA_W, 32, operand/immediate width
- STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..3; >1 for slow data memory)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- flush  in  1  taken branch/jump: squash the instruction entering EX
- id_valid  in  1  ID holds a real instruction
- id_reg_rs  in  5  rs field
- id_reg_rt  in  5  rt field
- id_reg_rd  in  5  rd field
- id_uses_rt  in  1  instruction reads rt as a source
- id_read_data_1  in  DATA_W  register-file rs value
- id_read_data_2  in  DATA_W  register-file rt value
- id_imm  in  DATA_W  sign-extended immediate
- id_ctrl  in  8  {reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, alu_op[1:0]}
- EX_reg_rs  out  5  to forwarding unit
- EX_reg_rt  out  5  to forwarding unit
- EX_reg_dest  out  5  reg_dst ? rd : rt, selected at capture
- EX_read_data_1  out  DATA_W  rs operand
- EX_read_data_2  out  DATA_W  rt operand
- EX_imm  out  DATA_W  immediate
- EX_ctrl  out  8  registered controls
- EX_valid  out  1  EX holds a real instruction
- pc_write  out  1  0 = hold PC
- if_id_write  out  1  0 = hold IF/ID
- stall  out  1  hazard stall active

Behaviour:
- Reset (reset=0, asynchronous): all EX_* outputs 0, EX_valid=0, stall=0, state IDLE, stall counter 0; pc_write=1, if_id_write=1.
- Hazard (combinational from registered state and ID inputs): haz = EX_valid & EX_ctrl.mem_read & (EX_reg_dest!=0) & id_valid & (EX_reg_dest==id_reg_rs | (id_uses_rt & EX_reg_dest==id_reg_rt)).
- FSM IDLE:
  - haz=0: capture ID fields next edge, 1-cycle latency.
  - haz=1 and flush=0: next edge loads a bubble (EX_ctrl=0, EX_valid=0, register fields 0, data fields don't-care but driven 0). If STALL_CYCLES>1, go to STALL with counter=STALL_CYCLES-1; else stay in IDLE.
- FSM STALL: insert a bubble each cycle and decrement the counter; when it reaches 0 return to IDLE. The held ID instruction is captured on the following edge.
- Stall outputs: stall = haz | (state==STALL); pc_write = if_id_write = ~stall. These are combinational and asserted in the same cycle the hazard is visible.
- flush=1 has priority over everything: next edge loads a bubble, state goes to IDLE, counter cleared, and no stall is generated by the squashed ID instruction (stall is forced 0 while flush=1).
- id_valid=0: capture as a bubble (EX_ctrl=0, EX_valid=0).
- EX_reg_dest is fixed at capture time and never recomputed.
- Destination register 0 never triggers a hazard.
- Reset asserted mid-stall: return to reset values immediately, no residual stall.

Optional Feature:
- Macro STALL_COUNTER_EN.
- Defined: adds output stall_count [31:0], incremented on every clock edge where stall=1 and flush=0. Saturates at 32'hFFFF_FFFF. Cleared by reset.
- Undefined: port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package mips_pkg: id_ctrl bit-index localparams (CTRL_REG_WRITE … CTRL_ALU_OP), CTRL_W=8, REG_ADDR_W=5, BUBBLE_CTRL=8'h00, FSM state encodings.
- One natural sub-module: load_use_detect (combinational haz equation), reusable by a future MEM-latency hazard unit.

Test Plan:
- Load-use on rs: EX holds lw $8 (mem_read=1, dest 8); ID holds add rs=8 -> stall=1, pc_write=0, if_id_write=0; next edge EX_valid=0, EX_ctrl=0; the edge after, EX_reg_rs=8 with add controls.
- No hazard on rt when id_uses_rt=0: lw dest 9, ID rt=9, uses_rt=0 -> stall=0, normal capture after 1 cycle.
- Dest zero: lw dest 0, ID rs=0 -> stall=0.
- STALL_CYCLES=3 with a hazard -> exactly 3 consecutive bubbles, stall high for 3 cycles, then capture.
- Flush during a hazard cycle: flush=1 with haz=1 -> stall=0, bubble loaded, state IDLE; flush=1 in STALL -> state IDLE next edge.
- Asynchronous reset mid-STALL: reset low between edges -> EX_* outputs immediately 0, stall=0; with STALL_COUNTER_EN, stall_count=0.
